// File: rtl/dmem_responder.sv
// Multi-cycle data-memory slave: accepts one read or write at a time, completes it after
// a fixed per-operation latency, and holds the CPU with stall until the rdy pulse.
module dmem_responder #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LAT     = 2,
  parameter int WR_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              re,
  input  logic              we,
  input  logic [DATA_W-1:0] wrt_data,
  input  logic              hlt,
  output logic [DATA_W-1:0] rd_data,
  output logic              rdy,
  output logic              stall,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] RD_CNT = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_CNT = 4'(WR_LAT - 1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  wr_op_q, wr_op_d;
  logic                  err_q, err_d;
  logic [DATA_W-1:0]     rd_data_q;
  logic                  rd_fire;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] rd_addr;

  logic [DATA_W-1:0] mem [0:(2**DEPTH_LOG2)-1];

  // Upper address bits alias onto the array by design.
  generate
    if (ADDR_W > DEPTH_LOG2) begin : g_unused_addr
      logic unused_addr_bits;
      assign unused_addr_bits = ^addr[ADDR_W-1:DEPTH_LOG2];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_op_d = wr_op_q;
    err_d   = 1'b0;
    rd_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (!hlt) begin
          if (re && we) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else if (re ^ we) begin
            addr_d  = addr[DEPTH_LOG2-1:0];
            data_d  = wrt_data;
            wr_op_d = we;
            cnt_d   = we ? WR_CNT : RD_CNT;
            if ((we ? WR_LAT : RD_LAT) == 1) begin
              state_d = DONE;
              rd_fire = re;
            end else begin
              state_d = BUSY;
            end
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
          rd_fire = ~wr_op_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_op_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_op_q <= wr_op_d;
      err_q   <= err_d;
    end
  end

  // A single-cycle read samples the live address; otherwise the latched one.
  assign rd_addr = (state_q == IDLE) ? addr[DEPTH_LOG2-1:0] : addr_q;
  assign mem_we  = (state_q == DONE) && wr_op_q && !err_q && !rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_fire) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rdy     = (state_q == DONE);
  assign err     = err_q;
  assign rd_data = rd_data_q;
  assign stall   = (re | we) & ~rdy & ~(re & we);

endmodule
